// File: rtl/bidir_bus_pkg.sv
// bidir_bus_pkg: shared state encoding and default geometry for the bidirectional bus port.
package bidir_bus_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_TURN_CYC = 2;
  localparam int DEF_MAX_BURST = 4;
  typedef enum logic [1:0] {IDLE, TURN_TX, DRIVE, TURN_RX} state_t;
endpackage

// File: rtl/bidir_turn_ctr.sv
// bidir_turn_ctr: loadable down-counter that saturates at zero and flags it.
module bidir_turn_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] init,
  input  logic         dec,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (load) cnt <= init;
    else if (dec && !zero) cnt <= cnt - 1'b1;
  end
  assign zero = (cnt == '0);
endmodule

// File: rtl/bidir_bus_port.sv
// bidir_bus_port: tri-state bus port with turnaround gaps and bounded bursts; BIDIR_BUS_CONTENTION_CHK_EN adds a sticky drive-contention check.
module bidir_bus_port
  import bidir_bus_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int TURN_CYC = DEF_TURN_CYC,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire  [WIDTH-1:0] bus_io,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  input  logic             rx_en,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             oe_o,
  output logic             busy,
  output logic             contention_err
);
  localparam int CW = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  state_t st, nxt;
  logic [WIDTH-1:0] out_q;
  logic oe_q, ld, dec, zero, rdy, acc;
  logic [7:0] burst;
  bidir_turn_ctr #(.W(CW)) u_ctr (
    .clk(clk),
    .rst(rst),
    .load(ld),
    .init(CW'(TURN_CYC - 1)),
    .dec(dec),
    .zero(zero)
  );
  always_ff @(posedge clk) begin
    if (rst) st <= IDLE;
    else st <= nxt;
  end
  always_comb begin
    nxt = st;
    ld = 1'b0;
    dec = 1'b0;
    rdy = 1'b0;
    case (st)
      IDLE: begin
        nxt = tx_valid ? TURN_TX : IDLE;
        ld = tx_valid;
      end
      TURN_TX: begin
        rdy = zero;
        dec = !zero;
        nxt = (tx_valid && zero) ? DRIVE : TURN_TX;
      end
      DRIVE: begin
        rdy = (burst < 8'(MAX_BURST));
        nxt = (tx_valid && rdy) ? DRIVE : TURN_RX;
        ld = !(tx_valid && rdy);
      end
      TURN_RX: begin
        dec = !zero;
        nxt = zero ? IDLE : TURN_RX;
      end
    endcase
  end
  assign acc = tx_valid && rdy;
  assign tx_ready = rdy && !rst;
  assign busy = (st != IDLE) && !rst;
  assign oe_o = oe_q;
  assign bus_io = oe_q ? out_q : {WIDTH{1'bz}};
  always_ff @(posedge clk) begin
    if (rst) begin
      oe_q <= 1'b0;
      out_q <= '0;
      burst <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
    end else begin
      if (acc) begin
        out_q <= tx_data;
        oe_q <= 1'b1;
        burst <= (st == DRIVE) ? burst + 8'd1 : 8'd1;
      end else if (st == DRIVE) begin
        oe_q <= 1'b0;
        burst <= '0;
      end
      rx_valid <= (st == IDLE) && rx_en;
      if ((st == IDLE) && rx_en) rx_data <= bus_io;
    end
  end
`ifdef BIDIR_BUS_CONTENTION_CHK_EN
  logic err;
  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (oe_q && (bus_io !== out_q)) err <= 1'b1;
  end
  assign contention_err = err;
`else
  assign contention_err = 1'b0;
`endif
endmodule

// File: tb/tb_bidir_bus_port.sv
// tb_bidir_bus_port: scoreboard bench; stimulus queues expected bus/rx words, a negedge monitor retires them.
module tb_bidir_bus_port;
  typedef struct {
    logic [7:0] data;
    int cyc;
  } bus_exp_t;
`ifdef BIDIR_BUS_CONTENTION_CHK_EN
  localparam logic CE = 1'b1;
`else
  localparam logic CE = 1'b0;
`endif
  logic clk, rst, tx_valid, tx_ready, rx_en, rx_valid, oe_o, busy, contention_err;
  logic [7:0] tx_data, rx_data, ext_val;
  logic ext_en;
  wire [7:0] bus;
  int cyc, tests, fails, c0;
  bus_exp_t expq[$];
  logic [7:0] rxq[$];
  logic [7:0] txq[$];
  bus_exp_t e;
  logic [7:0] r;
  assign bus = ext_en ? ext_val : 8'bz;
  bidir_bus_port dut (
    .clk(clk),
    .rst(rst),
    .bus_io(bus),
    .tx_valid(tx_valid),
    .tx_data(tx_data),
    .tx_ready(tx_ready),
    .rx_en(rx_en),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .oe_o(oe_o),
    .busy(busy),
    .contention_err(contention_err)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (oe_o) begin
      tests++;
      if (expq.size() == 0) begin
        fails++;
        $display("FAIL bus_drive unexpected: got %h at cycle %0d, required no drive", bus, cyc);
      end else begin
        e = expq.pop_front();
        if ((!ext_en && bus !== e.data) || cyc != e.cyc) begin
          fails++;
          $display("FAIL bus_word: got %h at cycle %0d, required %h at cycle %0d", bus, cyc, e.data, e.cyc);
        end
      end
    end
    if (rx_valid) begin
      tests++;
      if (rxq.size() == 0) begin
        fails++;
        $display("FAIL rx_unexpected: got %h, required no rx_valid", rx_data);
      end else begin
        r = rxq.pop_front();
        if (rx_data !== r) begin
          fails++;
          $display("FAIL rx_word: got %h, required %h", rx_data, r);
        end
      end
    end
  end
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask
  task automatic drain(input int limit);
    int k = 0;
    while (txq.size() > 0 && k < limit) begin
      tx_valid = 1;
      tx_data = txq[0];
      #1;
      if (tx_ready) void'(txq.pop_front());
      @(negedge clk);
      k++;
    end
    tx_valid = 0;
    chk("drain_done", txq.size(), 0);
  endtask
  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy && k < limit) begin
      @(negedge clk);
      k++;
    end
    chk("idle_reached", busy, 0);
  endtask
  initial begin
    tests = 0;
    fails = 0;
    rst = 1;
    tx_valid = 1;
    tx_data = 8'h00;
    rx_en = 0;
    ext_en = 0;
    ext_val = 0;
    repeat (3) @(negedge clk);
    chk("rst_oe", oe_o, 0);
    chk("rst_ready", tx_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_cerr", contention_err, 0);
    tx_valid = 0;
    rst = 0;
    @(negedge clk);
    // Full burst then a forced second tenure
    c0 = cyc;
    for (int i = 0; i < 6; i++) txq.push_back(8'hA1 + 8'(i));
    for (int i = 0; i < 4; i++) expq.push_back('{8'hA1 + 8'(i), c0 + 3 + i});
    expq.push_back('{8'hA5, c0 + 12});
    expq.push_back('{8'hA6, c0 + 13});
    drain(40);
    wait_idle(20);
    @(negedge clk);
    // Single word
    c0 = cyc;
    txq.push_back(8'h5C);
    expq.push_back('{8'h5C, c0 + 3});
    drain(20);
    @(negedge clk);
    chk("single_release1_oe", oe_o, 0);
    chk("single_release1_busy", busy, 1);
    @(negedge clk);
    chk("single_release2_oe", oe_o, 0);
    chk("single_release2_busy", busy, 1);
    @(negedge clk);
    chk("single_idle", busy, 0);
    // Receive path
    rx_en = 1;
    ext_en = 1;
    ext_val = 8'h3F;
    rxq.push_back(8'h3F);
    @(negedge clk);
    rx_en = 0;
    ext_en = 0;
    @(negedge clk);
    chk("rx_off_valid", rx_valid, 0);
    chk("rx_hold_data", rx_data, 8'h3F);
    // Sampling still happens in the IDLE cycle that leaves for TURN_TX
    c0 = cyc;
    rx_en = 1;
    ext_en = 1;
    ext_val = 8'h77;
    rxq.push_back(8'h77);
    tx_valid = 1;
    tx_data = 8'h11;
    expq.push_back('{8'h11, c0 + 3});
    @(negedge clk);
    rx_en = 0;
    ext_en = 0;
    txq.push_back(8'h11);
    drain(20);
    wait_idle(20);
    // Reset in the middle of a burst
    c0 = cyc;
    tx_valid = 1;
    tx_data = 8'hB0;
    expq.push_back('{8'hB0, c0 + 3});
    expq.push_back('{8'hB0, c0 + 4});
    repeat (4) @(negedge clk);
    rst = 1;
    tx_valid = 0;
    @(negedge clk);
    chk("mid_rst_oe", oe_o, 0);
    chk("mid_rst_ready", tx_ready, 0);
    chk("mid_rst_busy", busy, 0);
    rst = 0;
    @(negedge clk);
    chk("post_rst_idle", busy, 0);
    // Contention
    c0 = cyc;
    txq.push_back(8'hFF);
    expq.push_back('{8'hFF, c0 + 3});
    drain(20);
    #2;
    ext_en = 1;
    ext_val = 8'h00;
    @(negedge clk);
    ext_en = 0;
    chk("cerr_set", contention_err, CE);
    wait_idle(20);
    chk("cerr_sticky", contention_err, CE);
    rst = 1;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("cerr_cleared", contention_err, 0);
    // Drop tx_valid with the turnaround already expired
    c0 = cyc;
    tx_valid = 1;
    tx_data = 8'hD1;
    repeat (2) @(negedge clk);
    tx_valid = 0;
    #1;
    chk("turn_zero_ready", tx_ready, 1);
    repeat (3) @(negedge clk);
    expq.push_back('{8'hD1, c0 + 6});
    tx_valid = 1;
    #1;
    chk("resume_ready", tx_ready, 1);
    chk("resume_no_drive", oe_o, 0);
    @(negedge clk);
    tx_valid = 0;
    wait_idle(20);
    repeat (2) @(negedge clk);
    chk("bus_queue_empty", expq.size(), 0);
    chk("rx_queue_empty", rxq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/bidir_bus_port.md
BIDIR_BUS_PORT -- requirements
Module: bidir_bus_port

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bus and data width in bits, 1 or more.
REQ-002 SHALL have parameter TURN_CYC, default 2: released (hi-Z) turnaround cycles per direction change, 1 or more.
REQ-003 SHALL have parameter MAX_BURST, default 4: maximum words driven per bus tenure, 1 to 255.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port bus_io, inout, WIDTH bits: shared tri-state bus.
REQ-007 SHALL have port tx_valid, input, 1 bit: a transmit word is offered.
REQ-008 SHALL have port tx_data, input, WIDTH bits: the transmit word.
REQ-009 SHALL have port tx_ready, output, 1 bit: the word is accepted this cycle when tx_valid and tx_ready are both 1.
REQ-010 SHALL have port rx_en, input, 1 bit: enables bus sampling.
REQ-011 SHALL have port rx_data, output, WIDTH bits: sampled bus word.
REQ-012 SHALL have port rx_valid, output, 1 bit: rx_data is new this cycle.
REQ-013 SHALL have port oe_o, output, 1 bit: current drive enable, for observation.
REQ-014 SHALL have port busy, output, 1 bit: the state is not IDLE.
REQ-015 SHALL have port contention_err, output, 1 bit: sticky contention flag.

Function
REQ-016 SHALL implement four states: IDLE, TURN_TX, DRIVE and TURN_RX.
REQ-017 SHALL drive bus_io with registered out_q when oe_q=1, and with all-Z otherwise; oe_o = oe_q.
REQ-018 SHALL, in IDLE with tx_valid=1, go to TURN_TX and load the turnaround counter with TURN_CYC-1.
REQ-019 SHALL decrement the counter in TURN_TX; tx_ready=1 only when the counter is 0, and the counter holds at 0 while tx_valid=0.
REQ-020 SHALL, on an accept in TURN_TX or DRIVE: out_q<=tx_data; oe_q<=1; burst counter increments (it is set to 1 on the first accept); state becomes DRIVE.
REQ-021 SHALL set tx_ready=1 in DRIVE only while the burst count is below MAX_BURST; tx_ready=0 in every other case.
REQ-022 SHALL, in DRIVE with no accept (tx_valid=0 or burst limit reached): oe_q<=0; go to TURN_RX; reload the counter with TURN_CYC-1; clear the burst count.
REQ-023 SHALL hold each accepted word on the bus for exactly one cycle.
REQ-024 SHALL place the first word on the bus TURN_CYC+1 cycles after tx_valid rises in IDLE.
REQ-025 SHALL keep oe_q=0 in TURN_RX and return to IDLE when the counter is 0; tx_valid is ignored in TURN_RX.
REQ-026 SHALL, in IDLE with rx_en=1: rx_data<=bus_io and rx_valid<=1 at the next edge (one-cycle latency); otherwise rx_valid<=0 and rx_data holds.
REQ-027 SHALL still sample the bus in the IDLE cycle in which tx_valid=1 causes the exit to TURN_TX.
REQ-028 SHALL guarantee at least 2*TURN_CYC+1 released cycles between consecutive tenures.

Reset
REQ-029 SHALL, while rst=1 at a clock edge, force: state=IDLE; oe_q=0 (bus hi-Z from the next edge, including mid-DRIVE); out_q=0; rx_data=0; rx_valid=0; counters=0; contention_err=0.
REQ-030 SHALL hold tx_ready=0 and busy=0 during reset.

Configuration
REQ-031 SHALL, with macro BIDIR_BUS_CONTENTION_CHK_EN defined, compare bus_io against out_q (4-state !==) in every cycle where oe_q=1, and set contention_err on any mismatch; it stays set until rst.
REQ-032 SHALL, with BIDIR_BUS_CONTENTION_CHK_EN undefined, tie contention_err to 0 and omit the compare logic entirely.

Structure
REQ-033 SHALL keep the state enumeration and the default values of WIDTH, TURN_CYC and MAX_BURST in shared package bidir_bus_pkg.
REQ-034 SHALL use a single sub-module, bidir_turn_ctr: a loadable down-counter with a zero flag, instanced once and shared by TURN_TX and TURN_RX.

Verification (WIDTH=8, TURN_CYC=2, MAX_BURST=4)
REQ-035 SHALL check, with tx_valid held 1 from cycle 0 and tx_data 0xA1..0xA6: bus carries 0xA1,0xA2,0xA3,0xA4 in cycles 3-6; oe_o falls at cycle 7; oe_o rises again with 0xA5 at cycle 12.
REQ-036 SHALL check, for one word 0x5C and then tx_valid=0: 0x5C is on the bus for exactly one cycle; the bus is hi-Z for 2 cycles; then IDLE is reached.
REQ-037 SHALL check, in IDLE with rx_en=1 and an external driver putting 0x3F on the bus: rx_data=0x3F and rx_valid=1 one cycle later; with rx_en=0, rx_valid=0.
REQ-038 SHALL check that rst pulsed during DRIVE gives oe_o=0 and bus hi-Z at the next edge, tx_ready=0, and state IDLE.
REQ-039 SHALL check, with the macro defined, that an external driver forcing 0x00 while 0xFF is driven sets contention_err=1, which stays set until rst; with the macro undefined, it stays 0.
REQ-040 SHALL check, when tx_valid drops in TURN_TX with the counter at 0 and rises 3 cycles later: the word is accepted immediately (no second turnaround), and oe_o rises on the next edge.
